// File: rtl/alu_writeback_if.sv
// Result handshake bundle from the ALU into the writeback stage.
// Source drives payload and valid; the stage answers with ready.
interface alu_writeback_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  opcode;
  logic [3:0]  rdest;
  logic [15:0] c;
  logic [4:0]  flags;

  modport master (
    output in_valid,
    output opcode,
    output rdest,
    output c,
    output flags,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  opcode,
    input  rdest,
    input  c,
    input  flags,
    output in_ready
  );
endinterface

// File: rtl/alu_writeback.sv
// ALU writeback stage: in-order result queue committing into a
// 16x16 register file and the 5-bit status register.
module alu_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  alu_writeback_if.slave             result,
  input  logic                       hold,
  input  logic [3:0]                 rd_addr_a,
  input  logic [3:0]                 rd_addr_b,
  output logic [15:0]                rd_data_a,
  output logic [15:0]                rd_data_b,
  output logic [4:0]                 psr,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       wb_valid,
  output logic [3:0]                 wb_addr,
  output logic [15:0]                wb_data,
  output logic                       illegal
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [7:0]  opcode;
    logic [3:0]  rdest;
    logic [15:0] c;
    logic [4:0]  flags;
  } entry_t;

  typedef enum logic [1:0] {
    CL_ARITH,
    CL_CMP,
    CL_LOGIC,
    CL_BAD
  } cls_t;

  entry_t             q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [15:0]        rf [16];

  logic   full;
  logic   empty;
  logic   push;
  logic   pop;
  entry_t head;
  cls_t   cls;

  logic [7:0] op;
  logic [3:0] hi;
  logic       is_arith;
  logic       is_cmp;
  logic       is_logic;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  assign result.in_ready = rst_n && !full;

  assign push = result.in_valid && result.in_ready;
  assign pop  = !empty && !hold;

  assign head = q[rd_ptr];
  assign op   = head.opcode;
  assign hi   = op[7:4];

  assign is_arith = (op == 8'h05) || (op == 8'h09)
                 || (hi == 4'h5)  || (hi == 4'h9);

  assign is_cmp = (op == 8'h0B) || (hi == 4'hB);

  assign is_logic = (op == 8'h01) || (op == 8'h02)
                 || (op == 8'h03) || (op == 8'h0D)
                 || (hi == 4'h1)  || (hi == 4'h2)
                 || (hi == 4'h3)  || (hi == 4'hD)
                 || (hi == 4'hF)  || (op == 8'h84)
                 || (op[7:1] == 7'b1000_000);

  assign pending   = count;
  assign rd_data_a = rf[rd_addr_a];
  assign rd_data_b = rf[rd_addr_b];

  // Classify the head entry's opcode into its commit behaviour.
  always_comb begin
    cls = CL_BAD;
    unique case (1'b1)
      is_arith: cls = CL_ARITH;
      is_cmp:   cls = CL_CMP;
      is_logic: cls = CL_LOGIC;
      default:  cls = CL_BAD;
    endcase
  end

  // Queue payload storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      q[wr_ptr] <= '{
        opcode: result.opcode,
        rdest:  result.rdest,
        c:      result.c,
        flags:  result.flags
      };
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Commit the head into the register file and status register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++)
        rf[i] <= '0;
      psr      <= '0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      illegal  <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      illegal  <= 1'b0;
      if (pop) begin
        unique case (cls)
          CL_ARITH: begin
            rf[head.rdest] <= head.c;
            psr[4]         <= head.flags[4];
            psr[2]         <= head.flags[2];
            wb_valid       <= 1'b1;
            wb_addr        <= head.rdest;
            wb_data        <= head.c;
          end
          CL_CMP: begin
            psr[3] <= head.flags[3];
            psr[1] <= head.flags[1];
            psr[0] <= head.flags[0];
          end
          CL_LOGIC: begin
            rf[head.rdest] <= head.c;
            wb_valid       <= 1'b1;
            wb_addr        <= head.rdest;
            wb_data        <= head.c;
          end
          default: begin
            illegal <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: reset, flag rules,
// backpressure, illegal opcodes and read-during-write.
module tb_alu_writeback;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic [4:0]  psr;
  logic [2:0]  pending;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        illegal;

  int checks;
  int errors;

  alu_writeback_if bus ();

  alu_writeback #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .result    (bus.slave),
    .hold      (hold),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .psr       (psr),
    .pending   (pending),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [3:0] rd,
                       input logic [15:0] cv, input logic [4:0] fl);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.rdest    = rd;
    bus.c        = cv;
    bus.flags    = fl;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hold  = 1'b0;
    idle();
    bus.opcode = '0; bus.rdest = '0; bus.c = '0; bus.flags = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    tick();
    checks++;
    if (bus.in_ready !== 1'b0 || pending !== 3'd0 || psr !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b pend=%0d psr=%b want 0 0 0",
               bus.in_ready, pending, psr);
    end
    rst_n = 1'b1;
    tick();
    hold = 1'b1;
    drive(8'h05, 4'd1, 16'h1111, 5'b11111);
    tick();
    drive(8'h0D, 4'd2, 16'h2222, 5'b00000);
    tick();
    drive(8'h01, 4'd3, 16'h3333, 5'b00000);
    tick();
    idle();
    checks++;
    if (pending !== 3'd3) begin
      errors++;
      $display("FAIL reset_prefill: pending=%0d want 3", pending);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pending !== 3'd0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: pend=%0d rdy=%b want 0 0",
               pending, bus.in_ready);
    end
    tick();
    rst_n = 1'b1;
    hold  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (wb_valid !== 1'b0 || pending !== 3'd0) begin
        errors++;
        $display("FAIL reset_drain: wb_valid=%b pend=%0d want 0 0",
                 wb_valid, pending);
      end
    end
    checks++;
    if (bus.in_ready !== 1'b1 || psr !== 5'd0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b psr=%b want 1 00000",
               bus.in_ready, psr);
    end
    for (int r = 0; r < 16; r++) begin
      rd_addr_a = 4'(r);
      rd_addr_b = 4'(15 - r);
      #1;
      checks++;
      if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0) begin
        errors++;
        $display("FAIL reset_regs: r%0d a=%h b=%h want 0000",
                 r, rd_data_a, rd_data_b);
      end
    end
  endtask

  task automatic test_add();
    rd_addr_a = 4'd3;
    drive(8'h05, 4'd3, 16'h1234, 5'b10100);
    tick();
    idle();
    checks++;
    if (pending !== 3'd1 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_accept: pend=%0d wbv=%b want 1 0",
               pending, wb_valid);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_addr !== 4'd3 || wb_data !== 16'h1234) begin
      errors++;
      $display("FAIL add_wb: v=%b a=%0d d=%h want 1 3 1234",
               wb_valid, wb_addr, wb_data);
    end
    checks++;
    if (rd_data_a !== 16'h1234 || psr !== 5'b10100) begin
      errors++;
      $display("FAIL add_state: r3=%h psr=%b want 1234 10100",
               rd_data_a, psr);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_pulse: wb_valid=%b want 0", wb_valid);
    end
  endtask

  task automatic test_cmpi();
    rd_addr_b = 4'd2;
    drive(8'hB7, 4'd2, 16'hFFF6, 5'b01001);
    tick();
    idle();
    tick();
    checks++;
    if (psr !== 5'b11101 || wb_valid !== 1'b0 || rd_data_b !== 16'h0) begin
      errors++;
      $display("FAIL cmpi: psr=%b wbv=%b r2=%h want 11101 0 0000",
               psr, wb_valid, rd_data_b);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ops [4];
    logic [2:0] exp_pend [5];
    ops = '{8'h54, 8'h09, 8'h0D, 8'h03};
    exp_pend = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], 4'(4 + i), 16'(4 + i), 5'b00000);
      tick();
    end
    drive(8'hD8, 4'd8, 16'h0008, 5'b00000);
    checks++;
    if (pending !== 3'd4 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: pend=%0d rdy=%b want 4 0",
               pending, bus.in_ready);
    end
    tick();
    checks++;
    if (pending !== 3'd4 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall: pend=%0d wbv=%b want 4 0",
               pending, wb_valid);
    end
    hold = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 1) idle();
      checks++;
      if (wb_valid !== 1'b1 || wb_addr !== 4'(4 + k) ||
          wb_data !== 16'(4 + k) || pending !== exp_pend[k]) begin
        errors++;
        $display("FAIL bp_drain%0d: v=%b a=%0d d=%h p=%0d want 1 %0d %h %0d",
                 k, wb_valid, wb_addr, wb_data, pending,
                 4 + k, 16'(4 + k), exp_pend[k]);
      end
    end
    for (int r = 4; r <= 8; r++) begin
      rd_addr_a = 4'(r);
      #1;
      checks++;
      if (rd_data_a !== 16'(r)) begin
        errors++;
        $display("FAIL bp_regs: r%0d=%h want %h", r, rd_data_a, 16'(r));
      end
    end
    checks++;
    if (psr !== 5'b01001) begin
      errors++;
      $display("FAIL bp_psr: psr=%b want 01001", psr);
    end
  endtask

  task automatic test_illegal();
    rd_addr_a = 4'd1;
    drive(8'h40, 4'd1, 16'hBEEF, 5'b11111);
    tick();
    idle();
    tick();
    checks++;
    if (illegal !== 1'b1 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse: ill=%b wbv=%b want 1 0",
               illegal, wb_valid);
    end
    checks++;
    if (rd_data_a !== 16'h0 || psr !== 5'b01001) begin
      errors++;
      $display("FAIL illegal_state: r1=%h psr=%b want 0000 01001",
               rd_data_a, psr);
    end
    tick();
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_once: ill=%b want 0", illegal);
    end
  endtask

  task automatic test_read_during_write();
    rd_addr_a = 4'd9;
    drive(8'hD0, 4'd9, 16'h00AA, 5'b00000);
    tick();
    idle();
    #3;
    checks++;
    if (rd_data_a !== 16'h0000) begin
      errors++;
      $display("FAIL rdw_old: r9=%h want 0000", rd_data_a);
    end
    tick();
    checks++;
    if (rd_data_a !== 16'h00AA || wb_addr !== 4'd9) begin
      errors++;
      $display("FAIL rdw_new: r9=%h wa=%0d want 00aa 9",
               rd_data_a, wb_addr);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_cmpi();
    test_back_to_back();
    test_illegal();
    test_read_during_write();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback and status stage that sits on the result side of the ALU. It accepts one ALU result per handshake (C, Flags, the Opcode that produced it, destination register) into a small in-order queue. It commits each entry to a 16×16 register file and the 5-bit processor status register (PSR) according to per-opcode write and flag rules. It supplies two combinational register read ports for the operand-fetch side.

## Interface
- DEPTH, 4: result queue entries (power of two, ≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  result present
- in_ready  out  1  queue can accept (= rst_n && !full)
- opcode  in  8  ALU Opcode that produced the result
- rdest  in  4  destination register index
- c  in  16  ALU result C
- flags  in  5  ALU Flags: [4]=C carry/borrow, [3]=L low, [2]=F overflow, [1]=Z, [0]=N
- hold  in  1  stall commit (queue keeps filling)
- rd_addr_a, rd_addr_b  in  4  read addresses
- rd_data_a, rd_data_b  out  16  combinational register-array reads, no forwarding from queue
- psr  out  5  status register, same bit order as flags
- pending  out  $clog2(DEPTH+1)  queue occupancy
- wb_valid  out  1  registered one-cycle commit pulse
- wb_addr  out  4  register written (valid with wb_valid)
- wb_data  out  16  value written
- illegal  out  1  registered one-cycle pulse: unrecognised opcode committed

## Operation
- Accept: on a clk edge with in_valid && in_ready, push {opcode, rdest, c, flags}. No accept while full, even if a commit occurs in the same cycle.
- Commit: on a clk edge with !empty && !hold, pop the head and apply its class:
  - ADD 0000_0101, ADDI 0101_xxxx, SUB 0000_1001, SUBI 1001_xxxx: write R[rdest]=c; psr C,F := flags C,F; L,Z,N keep.
  - CMP 0000_1011, CMPI 1011_xxxx: no register write; psr L,Z,N := flags; C,F keep.
  - AND 0000_0001 / 0001_xxxx, OR 0000_0010 / 0010_xxxx, XOR 0000_0011 / 0011_xxxx, MOV 0000_1101 / 1101_xxxx, LUI 1111_xxxx, LSH 1000_0100, LSHI 1000_000x: write R[rdest]=c; psr unchanged.
  - Any other opcode: no write, psr unchanged, illegal pulses.
- Writes are full 16 bits. R0 is an ordinary register.
- Queue is a circular buffer: pointers wrap modulo DEPTH; pending = pushes − pops.

## Timing
- Reset (async assert): all registers cleared, psr=0, queue emptied, pending=0, wb_valid=0, wb_addr=0, wb_data=0, illegal=0, in_ready=0.
- After rst_n deasserts, in_ready=1.
- Latency: an entry accepted at edge N commits at edge N+1 at earliest (hold=0, queue empty before N).
  - rd_data reflects the new value after edge N+1.
  - wb_valid/illegal are high during cycle N+1 → N+2.
- Throughput: one accept and one commit per cycle. Simultaneous accept and commit leaves pending unchanged.
- Full: pending=DEPTH, in_ready=0. A held in_valid must keep its payload stable until accepted.
- Empty or hold=1: no commit, wb_valid=0, psr and registers stable.
- Read of a register being written at an edge: old value before the edge, new value after it.
- Reset mid-operation discards all queued entries; none commit after release.

## Test plan
- Reset: pulse rst_n low with pending=3 → after release pending=0, psr=0, all 16 reads return 0x0000, no wb_valid ever, in_ready=1.
- ADD: opcode=0x05, rdest=3, c=0x1234, flags=5'b10100 → one cycle later R3=0x1234, psr=5'b10100, wb_valid pulse with wb_addr=3, wb_data=0x1234.
- CMPI after the ADD: opcode=0xB7, rdest=2, c=0xFFF6, flags=5'b01001 → R2 stays 0, psr=5'b11101 (C,F kept; L=1, Z=0, N=1), wb_valid=0.
- Backpressure: hold=1, push ADDI, SUB, MOV, XOR to R4..R7 (c=0x0004..0x0007) → pending=4, in_ready=0, 5th beat (R8) stalls. Release hold → commits R4..R8 in order on consecutive cycles; final R4..R8 = 0x0004..0x0008.
- Illegal: opcode=0x40, rdest=1, c=0xBEEF → illegal pulses once, R1 unchanged, psr unchanged.
- Same-cycle read/write: rd_addr_a=9 while MOVI c=0x00AA commits to R9 → rd_data_a shows the old value before the edge and 0x00AA after it.
